// File: rtl/lii_pkg.sv
// Shared LII definitions: tag width, arbiter state encoding, beat tag struct, clog2 helper.
package lii_pkg;

  localparam int LII_TAG_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [LII_TAG_W-1:0] src;
    logic [LII_TAG_W-1:0] dst;
  } lii_tag_t;

  // Elaboration-time ceil(log2(value)), minimum 1 so single-bit indices stay legal.
  function automatic int lii_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lii_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping N-1 -> 0.
// Zero latency; no flow control of its own.
module lii_rr_pick
  import lii_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [lii_clog2(N)-1:0]   ptr,
  output logic                      any,
  output logic [lii_clog2(N)-1:0]   idx
);

  localparam int GW = lii_clog2(N);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [GW-1:0]  off;
  logic [GW:0]    sum;

  // Rotating a doubled copy puts the request at ptr in bit 0.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: N];

  always_comb begin
    any = 1'b0;
    off = '0;
    sum = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        off = GW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (GW + 1)'(N)) ? GW'(sum - (GW + 1)'(N)) : sum[GW-1:0];
  end

endmodule

// File: rtl/lii_out_arbiter.sv
// Round-robin burst scheduler of N kernel streams onto one LII phy channel; LII_ARB_STATS_EN adds per-requester beat counters.
// Latency: 1 cycle from accepted input beat to lii_out_p0_tvalid; 1-cycle bubble per grant.
// Backpressure: granted req_tready = !slice_vld | lii_out_p0_tready; a stalled beat is held stable.
module lii_out_arbiter
  import lii_pkg::*;
#(
  parameter int N     = 4,
  parameter int PW    = 256,
  parameter int BURST = 16
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic [N*PW-1:0]           req_tdata,
  input  logic [N-1:0]              req_tvalid,
  output logic [N-1:0]              req_tready,
  input  logic [LII_TAG_W-1:0]      cfg_src,
  input  logic [N*LII_TAG_W-1:0]    cfg_dst,
  output logic [PW-1:0]             lii_out_p0_tdata,
  output logic                      lii_out_p0_tvalid,
  input  logic                      lii_out_p0_tready,
  output logic [LII_TAG_W-1:0]      lii_out_p0_src,
  output logic [LII_TAG_W-1:0]      lii_out_p0_dst,
  output logic [lii_clog2(N)-1:0]   grant_id,
`ifdef LII_ARB_STATS_EN
  output logic [N*32-1:0]           stat_beats,
`endif
  output logic                      busy
);

  localparam int GW = lii_clog2(N);
  localparam int CW = lii_clog2(BURST + 1);

  arb_state_t     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           pick_any;
  logic [GW-1:0]  pick_idx;
  logic [GW-1:0]  next_ptr;

  logic           slice_vld;
  logic [PW-1:0]  slice_dat;
  lii_tag_t       slice_tag;

  logic           g_vld;
  logic           in_rdy;
  logic           in_xfer;
  logic [PW-1:0]  g_dat;
  logic [LII_TAG_W-1:0] g_dst;

  lii_rr_pick #(.N(N)) u_pick (
    .req (req_tvalid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign g_vld    = req_tvalid[grant_q];
  assign g_dat    = req_tdata[grant_q*PW +: PW];
  assign g_dst    = cfg_dst[grant_q*LII_TAG_W +: LII_TAG_W];
  assign in_rdy   = !slice_vld || lii_out_p0_tready;
  assign in_xfer  = (state_q == LOCK) && g_vld && in_rdy;
  assign next_ptr = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    req_tready = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_tready[grant_q] = in_rdy;
        if (in_xfer) cnt_d = cnt_q + CW'(1);
        // Burst exhausted or requester went quiet: hand over; no same-cycle regrant.
        if ((in_xfer && (cnt_q == CW'(BURST - 1))) || !g_vld) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output slice: load wins over drain so a beat can enter while the previous one leaves.
  always_ff @(posedge aclk) begin
    if (arst) begin
      slice_vld <= 1'b0;
      slice_dat <= '0;
      slice_tag <= '0;
    end else if (in_xfer) begin
      slice_vld <= 1'b1;
      slice_dat <= g_dat;
      slice_tag <= '{src: cfg_src, dst: g_dst};
    end else if (lii_out_p0_tready) begin
      slice_vld <= 1'b0;
    end
  end

  assign lii_out_p0_tvalid = slice_vld;
  assign lii_out_p0_tdata  = slice_dat;
  assign lii_out_p0_src    = slice_tag.src;
  assign lii_out_p0_dst    = slice_tag.dst;
  assign grant_id          = grant_q;
  assign busy              = (state_q == LOCK) || slice_vld;

`ifdef LII_ARB_STATS_EN
  logic [N-1:0][31:0] stat_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      stat_q <= '0;
    end else if (in_xfer) begin
      stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
    end
  end

  assign stat_beats = stat_q;
`endif

endmodule
